// File: rtl/mips_cpu_muldiv_pkg.sv
// rtl/mips_cpu_muldiv_pkg.sv - funct codes, FSM state type and decode helpers for the HI/LO issue controller
package mips_cpu_muldiv_pkg;

   localparam logic [5:0] FN_NOP   = 6'b000000;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MTHI  = 6'b010001;
   localparam logic [5:0] FN_MFLO  = 6'b010010;
   localparam logic [5:0] FN_MTLO  = 6'b010011;
   localparam logic [5:0] FN_MULT  = 6'b011000;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_DIV   = 6'b011010;
   localparam logic [5:0] FN_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      READ  = 2'd3
   } state_e;

   function automatic logic is_hilo_funct(input logic [5:0] f);
      return f inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO,
                       FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
   endfunction

   function automatic logic is_mf_funct(input logic [5:0] f);
      return (f == FN_MFHI) || (f == FN_MFLO);
   endfunction

endpackage

// File: rtl/mips_cpu_muldiv_if.sv
// rtl/mips_cpu_muldiv_if.sv - decode/writeback and HI/LO unit signals of the muldiv controller
// MIPS_MULDIV_DIV0_TRAP_EN adds the div0 pulse.
interface mips_cpu_muldiv_if;
   logic        op_valid;
   logic [5:0]  funct;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        stall;
   logic        mf_valid;
   logic [31:0] mf_data;
   logic        err;
   logic [5:0]  hl_opcode;
   logic [31:0] hl_a;
   logic [31:0] hl_b;
   logic        hl_valid_in;
   logic        hl_valid_out;
   logic [31:0] hl_hi;
   logic [31:0] hl_lo;
`ifdef MIPS_MULDIV_DIV0_TRAP_EN
   logic        div0;
`endif

   modport slave (
      input  op_valid, funct, rs_val, rt_val, hl_valid_out, hl_hi, hl_lo,
      output stall, mf_valid, mf_data, err, hl_opcode, hl_a, hl_b, hl_valid_in
`ifdef MIPS_MULDIV_DIV0_TRAP_EN
      , output div0
`endif
   );

   modport master (
      output op_valid, funct, rs_val, rt_val, hl_valid_out, hl_hi, hl_lo,
      input  stall, mf_valid, mf_data, err, hl_opcode, hl_a, hl_b, hl_valid_in
`ifdef MIPS_MULDIV_DIV0_TRAP_EN
      , input div0
`endif
   );

endinterface

// File: rtl/mips_cpu_muldiv_timer.sv
// rtl/mips_cpu_muldiv_timer.sv - 8-bit saturating wait counter with fixed-latency and divide-timeout compares
module mips_cpu_muldiv_timer #(
   parameter int FIXED_LAT   = 2,
   parameter int DIV_TIMEOUT = 40
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_clr,
   input  logic i_en,
   output logic o_lat_hit,
   output logic o_timeout
);
   localparam logic [7:0] LAT_CMP = FIXED_LAT[7:0];
   localparam logic [7:0] TMO_CMP = DIV_TIMEOUT[7:0];

   logic [7:0] r_cnt;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt <= 8'd0;
      end else if (i_clr) begin
         r_cnt <= 8'd0;
      end else if (i_en && (r_cnt != 8'hFF)) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   assign o_lat_hit = (r_cnt >= LAT_CMP);
   assign o_timeout = (r_cnt >= TMO_CMP);

endmodule

// File: rtl/mips_cpu_muldiv_ctrl.sv
// rtl/mips_cpu_muldiv_ctrl.sv - issue/stall controller in front of the HI/LO multiply/divide unit
// MIPS_MULDIV_DIV0_TRAP_EN: divide by zero is accepted without issue and flagged on div0.
module mips_cpu_muldiv_ctrl
   import mips_cpu_muldiv_pkg::*;
#(
   parameter int FIXED_LAT   = 2,
   parameter int DIV_TIMEOUT = 40
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   mips_cpu_muldiv_if.slave bus
);

   state_e      r_state;
   state_e      w_next_state;
   logic [5:0]  r_opcode;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic [31:0] r_mf_data;
   logic        r_err;

   logic w_take;
   logic w_trap;
   logic w_accept_mf;
   logic w_accept_op;
   logic w_is_div;
   logic w_lat_hit;
   logic w_timeout_hit;
   logic w_wait_exit;
   logic w_div_abort;
   logic w_timer_clr;
   logic w_timer_en;

   assign w_take = (r_state == IDLE) && bus.op_valid && is_hilo_funct(bus.funct);

`ifdef MIPS_MULDIV_DIV0_TRAP_EN
   assign w_trap = w_take && ((bus.funct == FN_DIV) || (bus.funct == FN_DIVU))
                   && (bus.rt_val == 32'd0);
`else
   assign w_trap = 1'b0;
`endif

   assign w_accept_mf = w_take && is_mf_funct(bus.funct);
   assign w_accept_op = w_take && !is_mf_funct(bus.funct) && !w_trap;

   // Only signed DIV has a data-dependent latency; DIVU runs on the fixed timer.
   assign w_is_div    = (r_opcode == FN_DIV);
   assign w_wait_exit = w_is_div ? (bus.hl_valid_out || w_timeout_hit) : w_lat_hit;
   assign w_div_abort = (r_state == WAIT) && w_is_div && !bus.hl_valid_out && w_timeout_hit;

   mips_cpu_muldiv_timer #(
      .FIXED_LAT   (FIXED_LAT),
      .DIV_TIMEOUT (DIV_TIMEOUT)
   ) u_timer (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_clr     (w_timer_clr),
      .i_en      (w_timer_en),
      .o_lat_hit (w_lat_hit),
      .o_timeout (w_timeout_hit)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_accept_mf) begin
               w_next_state = READ;
            end else if (w_accept_op) begin
               w_next_state = ISSUE;
            end
         end
         ISSUE:   w_next_state = WAIT;
         WAIT:    if (w_wait_exit) w_next_state = IDLE;
         READ:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      bus.stall       = bus.op_valid && (r_state != IDLE);
      bus.hl_valid_in = (r_state == ISSUE);
      bus.mf_valid    = (r_state == READ);
      w_timer_clr     = (r_state == ISSUE);
      w_timer_en      = (r_state == WAIT);
   end

   // Opcode and operands stay frozen from acceptance until WAIT exits.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_opcode  <= FN_NOP;
         r_a       <= 32'd0;
         r_b       <= 32'd0;
         r_mf_data <= 32'd0;
         r_err     <= 1'b0;
      end else begin
         if (w_accept_op) begin
            r_opcode <= bus.funct;
            r_a      <= bus.rs_val;
            r_b      <= bus.rt_val;
         end else if ((r_state == WAIT) && w_wait_exit) begin
            r_opcode <= FN_NOP;
         end
         if (w_accept_mf) begin
            r_mf_data <= (bus.funct == FN_MFHI) ? bus.hl_hi : bus.hl_lo;
         end
         if (w_div_abort) begin
            r_err <= 1'b1;
         end
      end
   end

`ifdef MIPS_MULDIV_DIV0_TRAP_EN
   logic r_div0;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div0 <= 1'b0;
      end else begin
         r_div0 <= w_trap;
      end
   end

   assign bus.div0 = r_div0;
`endif

   assign bus.hl_opcode = r_opcode;
   assign bus.hl_a      = r_a;
   assign bus.hl_b      = r_b;
   assign bus.mf_data   = r_mf_data;
   assign bus.err       = r_err;

endmodule

// File: doc/mips_cpu_muldiv_ctrl.md
Name: mips_cpu_muldiv_ctrl

Overview:
Issue and stall controller directly upstream of the HI/LO multiply/divide unit. It takes decoded SPECIAL-funct instructions and register operands from the core, sequences them into the HI/LO unit, and holds opcode and operands stable for multi-cycle operations. It stalls the pipeline while the unit is busy and returns MFHI/MFLO results to writeback.

Parameters:
FIXED_LAT, 2, cycles after issue before MTHI/MTLO/MULT/MULTU results are valid on hl_hi/hl_lo (range 1..15)
DIV_TIMEOUT, 40, max cycles to wait for hl_valid_out on DIV before aborting (range 2..255)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-low reset
op_valid  in  1  decode presents a HI/LO-class instruction this cycle
funct  in  6  SPECIAL funct field: MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011, MULT 011000, MULTU 011001, DIV 011010, DIVU 011011
rs_val  in  32  rs operand
rt_val  in  32  rt operand
stall  out  1  hold decode; the instruction is not accepted
mf_valid  out  1  one-cycle pulse: mf_data is valid for writeback
mf_data  out  32  MFHI/MFLO result
err  out  1  sticky DIV timeout flag
hl_opcode  out  6  to HI/LO unit opcode
hl_a  out  32  to HI/LO unit operand a
hl_b  out  32  to HI/LO unit operand b
hl_valid_in  out  1  to HI/LO unit start pulse
hl_valid_out  in  1  from HI/LO unit: DIV result ready
hl_hi  in  32  from HI/LO unit
hl_lo  in  32  from HI/LO unit

Behaviour:
- Reset (async assert): state=IDLE, stall=0, mf_valid=0, mf_data=0, err=0, hl_opcode=000000, hl_a=0, hl_b=0, hl_valid_in=0, counter=0.
- Reset mid-operation: the operation is abandoned. No retry occurs and no mf_valid is produced.
- States: IDLE, ISSUE, WAIT, READ.
- IDLE:
  - op_valid with funct not in the list above is ignored; no stall.
  - Accept any listed funct in IDLE.
  - MFHI/MFLO → READ.
  - All others: latch hl_opcode=funct, hl_a=rs_val, hl_b=rt_val → ISSUE.
- ISSUE (exactly 1 cycle): hl_valid_in=1, counter cleared → WAIT.
- WAIT:
  - hl_opcode, hl_a and hl_b are held unchanged.
  - Non-DIV ops: leave after counter reaches FIXED_LAT.
  - DIV: leave on the first cycle hl_valid_out=1.
  - Exit action: hl_opcode=000000 → IDLE.
- DIV timeout: if counter reaches DIV_TIMEOUT with no hl_valid_out, set err (sticky until reset), hl_opcode=000000 → IDLE.
- DIVU is treated as a fixed-latency op (FIXED_LAT).
- READ (1 cycle): mf_data <= funct==MFHI ? hl_hi : hl_lo; mf_valid=1 → IDLE. An MF result is therefore valid one cycle after acceptance.
- stall = op_valid && state!=IDLE, combinational. Decode re-presents the same instruction until stall=0.
- Back-to-back MULT then MFHI: MFHI stalls through ISSUE/WAIT and is accepted on the IDLE cycle, so it always sees the updated HI.
- hl_valid_in is never high outside ISSUE. No two issues occur without an intervening IDLE cycle.
- Counter is 8 bits, saturating; it never wraps.

Optional Feature:
MIPS_MULDIV_DIV0_TRAP_EN
- Defined:
  - DIV/DIVU with rt_val==0 in IDLE is accepted but not issued.
  - The HI/LO unit is untouched; hl_valid_in stays 0.
  - Output div0 (1 bit, extra port, reset 0) pulses for 1 cycle and state stays IDLE (no stall).
- Undefined: the div0 port is absent and divide-by-zero issues normally.

Decomposition:
- Package mips_cpu_muldiv_pkg:
  - funct localparams (FN_MFHI … FN_DIVU, FN_NOP=000000)
  - state enum {IDLE, ISSUE, WAIT, READ}
  - function is_hilo_funct()
- Sub-module mips_cpu_muldiv_timer:
  - 8-bit saturating counter with clear/enable
  - compare outputs for FIXED_LAT and DIV_TIMEOUT

Test Plan:
- MULTU rs=0x0001_0000, rt=0x0001_0000 (bench HI/LO model, FIXED_LAT=2), then MFHI → one hl_valid_in pulse with hl_opcode=011001; MFHI stalls ≥3 cycles, then mf_data=0x0000_0001, mf_valid one cycle later.
- MTLO rs=0xDEAD_BEEF then MFLO → mf_data=0xDEAD_BEEF; stall deasserts exactly when state returns to IDLE.
- DIV 100/7, model asserts hl_valid_out after 34 cycles → hl_opcode stays 011010 and hl_a=100, hl_b=7 for all of WAIT; MFLO/MFHI then return 14 and 2.
- DIV with model never asserting hl_valid_out → err=1 at DIV_TIMEOUT cycles after ISSUE, hl_opcode=000000; a following MTHI is accepted normally.
- Reset pulled low during DIV WAIT → all outputs zero immediately (async); after release, an MFHI proceeds with no stall.
- With MIPS_MULDIV_DIV0_TRAP_EN: DIVU rt=0 → div0 pulse, hl_valid_in never high, stall=0; an MFLO afterwards returns the previous LO.
